// File: rtl/accum_pkg.sv
// Shared types and default widths for the accumulate_hist block.
package accum_pkg;

   typedef enum logic [1:0] {
      OP_ADD  = 2'b00,
      OP_SUB  = 2'b01,
      OP_LOAD = 2'b10,
      OP_UNDO = 2'b11
   } op_t;

   localparam int DATA_W_DEF = 8;
   localparam int ACC_W_DEF  = 10;
   localparam int DEPTH_DEF  = 4;

endpackage

// File: rtl/accumulate_hist_key_edge.sv
// key_edge: two-flop synchronizer plus history flop on an active-low
// pushbutton. fall pulses for one cycle on each press (1 -> 0 transition).
// All stages reset to 0 ("pressed") so a key held through reset never fires.
module key_edge (
   input  logic clk,
   input  logic resetn,
   input  logic key,
   output logic fall
);

   logic sync1, sync2, hist;

   // Synchronize the raw key and keep one cycle of history for edge detection
   always_ff @(posedge clk) begin
      if (!resetn) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         hist  <= 1'b0;
      end else begin
         sync1 <= key;
         sync2 <= sync1;
         hist  <= sync2;
      end
   end

   assign fall = hist & ~sync2;

endmodule

// File: rtl/accumulate_hist.sv
// accumulate_hist: step-key driven accumulator with add/sub/load/undo,
// a circular LIFO undo history, sticky overflow flag and a done strobe.
// Build option: define ACCUM_SATURATE_EN to clamp on overflow/borrow
// instead of wrapping.
module accumulate_hist
   import accum_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ACC_W  = ACC_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic                       Clock,
   input  logic                       Resetn,
   input  logic                       Step,
   input  logic [1:0]                 Op,
   input  logic [DATA_W-1:0]          Data,
   output logic [ACC_W-1:0]           Acc,
   output logic                       Ovf,
   output logic [$clog2(DEPTH+1)-1:0] Depth,
   output logic                       Done
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH+1);

   logic             evt;
   op_t              op;
   logic [ACC_W-1:0] data_ext;
   logic [ACC_W:0]   sum, diff;
   logic [ACC_W-1:0] add_val, sub_val;
   logic [PTR_W-1:0] wptr, wptr_inc, rptr;
   logic [ACC_W-1:0] hist_mem [DEPTH];
   logic             push;

   key_edge u_key (
      .clk    (Clock),
      .resetn (Resetn),
      .key    (Step),
      .fall   (evt)
   );

   assign op       = op_t'(Op);
   assign data_ext = ACC_W'(Data);
   assign push     = evt && (op != OP_UNDO);

   // wptr is the next free slot; the top of the stack sits just below it
   assign wptr_inc = (wptr == PTR_W'(DEPTH-1)) ? '0 : wptr + 1'b1;
   assign rptr     = (wptr == '0) ? PTR_W'(DEPTH-1) : wptr - 1'b1;

   // Arithmetic at ACC_W+1 bits; the top bit is carry (add) or borrow (sub)
   always_comb begin
      sum     = {1'b0, Acc} + {1'b0, data_ext};
      diff    = {1'b0, Acc} - {1'b0, data_ext};
      add_val = sum[ACC_W-1:0];
      sub_val = diff[ACC_W-1:0];
`ifdef ACCUM_SATURATE_EN
      if (sum[ACC_W])  add_val = '1;
      if (diff[ACC_W]) sub_val = '0;
`endif
   end

   // History storage: pre-operation value is pushed; contents need no reset
   always_ff @(posedge Clock) begin
      if (push) hist_mem[wptr] <= Acc;
   end

   // Accumulator, flag, history bookkeeping and completion strobe
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         Acc   <= '0;
         Ovf   <= 1'b0;
         Depth <= '0;
         Done  <= 1'b0;
         wptr  <= '0;
      end else begin
         Done <= 1'b0;
         if (evt) begin
            unique case (op)
               OP_ADD: begin
                  Acc <= add_val;
                  if (sum[ACC_W]) Ovf <= 1'b1;
               end
               OP_SUB: begin
                  Acc <= sub_val;
                  if (diff[ACC_W]) Ovf <= 1'b1;
               end
               OP_LOAD: begin
                  Acc <= data_ext;
                  Ovf <= 1'b0;
               end
               OP_UNDO: begin
                  if (Depth != '0) begin
                     Acc   <= hist_mem[rptr];
                     wptr  <= rptr;
                     Depth <= Depth - 1'b1;
                     Done  <= 1'b1;
                  end
               end
            endcase
            if (push) begin
               wptr <= wptr_inc;
               Done <= 1'b1;
               if (Depth != CNT_W'(DEPTH)) Depth <= Depth + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_accumulate_hist.sv
// Self-checking bench for accumulate_hist: directed test plan steps plus
// randomized presses against a queue-based reference model.
module tb_accumulate_hist;

   localparam int DATA_W = 8;
   localparam int ACC_W  = 10;
   localparam int DEPTH  = 4;
   localparam int MODV   = 1 << ACC_W;

   logic                       Clock = 1'b0;
   logic                       Resetn = 1'b0;
   logic                       Step = 1'b1;
   logic [1:0]                 Op = 2'b00;
   logic [DATA_W-1:0]          Data = '0;
   logic [ACC_W-1:0]           Acc;
   logic                       Ovf;
   logic [$clog2(DEPTH+1)-1:0] Depth;
   logic                       Done;

   int vectors = 0;
   int miscompares = 0;

   // reference model state
   int unsigned m_acc = 0;
   bit          m_ovf = 0;
   int unsigned m_hist[$];

   accumulate_hist #(.DATA_W(DATA_W), .ACC_W(ACC_W), .DEPTH(DEPTH)) dut (
      .Clock  (Clock),
      .Resetn (Resetn),
      .Step   (Step),
      .Op     (Op),
      .Data   (Data),
      .Acc    (Acc),
      .Ovf    (Ovf),
      .Depth  (Depth),
      .Done   (Done)
   );

   always #10 Clock = ~Clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void m_reset();
      m_acc = 0;
      m_ovf = 0;
      m_hist.delete();
   endfunction

   function automatic void m_push(input int unsigned v);
      m_hist.push_back(v);
      if (m_hist.size() > DEPTH) void'(m_hist.pop_front());
   endfunction

   // returns whether the operation is applied (Done expected)
   function automatic bit m_apply(input logic [1:0] op, input int unsigned d);
      int unsigned s;
      case (op)
         2'b00: begin
            m_push(m_acc);
            s = m_acc + d;
            if (s >= MODV) begin
               m_ovf = 1;
`ifdef ACCUM_SATURATE_EN
               m_acc = MODV - 1;
`else
               m_acc = s - MODV;
`endif
            end else m_acc = s;
            return 1;
         end
         2'b01: begin
            m_push(m_acc);
            if (d > m_acc) begin
               m_ovf = 1;
`ifdef ACCUM_SATURATE_EN
               m_acc = 0;
`else
               m_acc = m_acc + MODV - d;
`endif
            end else m_acc = m_acc - d;
            return 1;
         end
         2'b10: begin
            m_push(m_acc);
            m_acc = d;
            m_ovf = 0;
            return 1;
         end
         default: begin
            if (m_hist.size() == 0) return 0;
            m_acc = m_hist.pop_back();
            return 1;
         end
      endcase
   endfunction

   task automatic do_reset();
      @(negedge Clock);
      Resetn = 1'b0;
      repeat (2) @(posedge Clock);
      #1;
      chk("rst_acc", 32'(Acc), 0);
      chk("rst_ovf", 32'(Ovf), 0);
      chk("rst_depth", 32'(Depth), 0);
      chk("rst_done", 32'(Done), 0);
      m_reset();
      @(negedge Clock);
      Resetn = 1'b1;
      repeat (4) @(negedge Clock);
   endtask

   // one press: Step goes low just before edge 1; result expected on edge 3
   task automatic press(input logic [1:0] op, input logic [7:0] d);
      int unsigned pre_acc;
      bit          exp_done;
      pre_acc = m_acc;
      @(negedge Clock);
      Op = op;
      Data = d;
      Step = 1'b0;
      repeat (2) @(posedge Clock);
      #1;
      chk("early_acc", 32'(Acc), pre_acc);
      chk("early_done", 32'(Done), 0);
      exp_done = m_apply(op, d);
      @(posedge Clock);
      #1;
      chk("acc", 32'(Acc), m_acc);
      chk("ovf", 32'(Ovf), 32'(m_ovf));
      chk("depth", 32'(Depth), m_hist.size());
      chk("done", 32'(Done), 32'(exp_done));
      @(posedge Clock);
      #1;
      chk("done_1cyc", 32'(Done), 0);
      @(negedge Clock);
      Step = 1'b1;
      // scramble Op/Data while idle; must not affect anything
      Op = 2'($urandom_range(0, 3));
      Data = 8'($urandom_range(0, 255));
      repeat (4) @(negedge Clock);
      chk("idle_acc", 32'(Acc), m_acc);
   endtask

   initial begin
      int pulses;
      // 1: reset, three ADD 5
      do_reset();
      repeat (3) press(2'b00, 8'h05);
      chk("add3_acc", 32'(Acc), 15);
      chk("add3_depth", 32'(Depth), 3);

      // 2: carry into overflow, then LOAD clears it
      press(2'b10, 8'hFF);
      repeat (3) press(2'b00, 8'hFF);
      chk("pre_ovf_acc", 32'(Acc), 32'h3FC);
      chk("pre_ovf_flag", 32'(Ovf), 0);
      press(2'b00, 8'hFF);
`ifdef ACCUM_SATURATE_EN
      chk("ovf_acc", 32'(Acc), 32'h3FF);
`else
      chk("ovf_acc", 32'(Acc), 32'h0FB);
`endif
      chk("ovf_flag", 32'(Ovf), 1);
      press(2'b10, 8'h00);
      chk("load_clr_ovf", 32'(Ovf), 0);

      // 3: borrow
      press(2'b10, 8'h03);
      press(2'b01, 8'h05);
`ifdef ACCUM_SATURATE_EN
      chk("borrow_acc", 32'(Acc), 0);
`else
      chk("borrow_acc", 32'(Acc), 32'h3FE);
`endif
      chk("borrow_flag", 32'(Ovf), 1);

      // 4: history overwrite and undo to empty
      do_reset();
      press(2'b10, 8'h01);
      repeat (4) press(2'b00, 8'h01);
      chk("full_depth", 32'(Depth), DEPTH);
      repeat (5) press(2'b11, 8'h00);
      chk("undo_acc", 32'(Acc), 1);
      chk("undo_depth", 32'(Depth), 0);

      // 5: held key gives one event; held through reset gives none
      @(negedge Clock);
      Op = 2'b00;
      Data = 8'h07;
      Step = 1'b0;
      void'(m_apply(2'b00, 7));
      pulses = 0;
      repeat (100) begin
         @(negedge Clock);
         if (Done) pulses++;
      end
      chk("held_pulses", pulses, 1);
      chk("held_acc", 32'(Acc), m_acc);
      Resetn = 1'b0;
      repeat (2) @(posedge Clock);
      #1;
      chk("held_rst_acc", 32'(Acc), 0);
      m_reset();
      @(negedge Clock);
      Resetn = 1'b1;
      pulses = 0;
      repeat (20) begin
         @(negedge Clock);
         if (Done) pulses++;
      end
      chk("held_after_rst_pulses", pulses, 0);
      chk("held_after_rst_acc", 32'(Acc), 0);
      Step = 1'b1;
      repeat (4) @(negedge Clock);
      press(2'b00, 8'h03);
      chk("repress_acc", 32'(Acc), 3);

      // 6: pushes, reset, undo on empty history
      repeat (3) press(2'b00, 8'($urandom_range(0, 255)));
      do_reset();
      press(2'b11, 8'h00);

      // 7: randomized presses against the model
      for (int i = 0; i < 40; i++)
         press(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
